// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator; all outputs registered and updated on pix_en edges.
// Optional frame-derived game_tick enabled by defining VGA_GAME_TICK_EN.
module vga_timing #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int FRAMES_PER_TICK = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       game_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || FRAMES_PER_TICK < 1) begin : g_bad_cfg
        $error("vga_timing: totals must be <= 1024 and FRAMES_PER_TICK >= 1");
    end

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;

    // x/y are the counters themselves; decodes look at the next values so
    // sync and blank land on the same edge as the coordinates.
    always_comb begin
        h_wrap = (x == H_LAST);
        v_wrap = h_wrap && (y == V_LAST);
        hc_nxt = h_wrap ? 10'd0 : x + 10'd1;
        if (v_wrap)
            vc_nxt = 10'd0;
        else if (h_wrap)
            vc_nxt = y + 10'd1;
        else
            vc_nxt = y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= 10'd0;
            y           <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x           <= hc_nxt;
                y           <= vc_nxt;
                hsync       <= !((hc_nxt >= HS_START) && (hc_nxt < HS_END));
                vsync       <= !((vc_nxt >= VS_START) && (vc_nxt < VS_END));
                video_on    <= (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
                line_start  <= h_wrap;
                frame_start <= v_wrap;
            end
        end
    end

`ifdef VGA_GAME_TICK_EN
    localparam int FC_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_TICK - 1);

    logic [FC_W-1:0] fc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fc        <= '0;
            game_tick <= 1'b0;
        end else begin
            game_tick <= 1'b0;
            if (pix_en && v_wrap) begin
                fc        <= (fc == FC_LAST) ? '0 : fc + 1'b1;
                game_tick <= (fc == FC_LAST);
            end
        end
    end
`else
    assign game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with shrunk timing parameters; reference model tracks pixel count.
module tb_vga_timing;
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int FPT = 2;
    localparam int HT = HV + HF + HS + HB;   // 30
    localparam int VT = VV + VF + VS + VB;   // 17
    localparam int FT = HT * VT;             // 510

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync, vsync, video_on, line_start, frame_start, game_tick;
    logic [9:0] x, y;

    vga_timing #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FRAMES_PER_TICK(FPT)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .game_tick(game_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gcnt = 0;

    // Reference: p = number of pixel advances since reset.
    int p = 0;
    bit m_ls, m_fs, m_gt;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic int expected_vec();
        int ex, ey;
        bit ehs, evs, evo;
        ex  = p % HT;
        ey  = (p / HT) % VT;
        ehs = !(ex >= HV + HF && ex < HV + HF + HS);
        evs = !(ey >= VV + VF && ey < VV + VF + VS);
        evo = (ex < HV) && (ey < VV);
        return int'({ehs, evs, evo, 10'(ex), 10'(ey), m_ls, m_fs, m_gt});
    endfunction

    task automatic step(input bit r, input bit pe);
        rst = r;
        pix_en = pe;
        @(posedge clk);
        gcnt++;
        if (r) begin
            p = 0;
            m_ls = 0; m_fs = 0; m_gt = 0;
        end else if (pe) begin
            p++;
            m_ls = (p % HT) == 0;
            m_fs = (p % FT) == 0;
`ifdef VGA_GAME_TICK_EN
            m_gt = m_fs && (((p / FT) % FPT) == 0);
`else
            m_gt = 0;
`endif
        end else begin
            m_ls = 0; m_fs = 0; m_gt = 0;
        end
        @(negedge clk);
        check("outputs", int'({hsync, vsync, video_on, x, y, line_start, frame_start, game_tick}),
              expected_vec());
    endtask

    // Run with pix_en every div cycles until the chosen strobe; cyc=-1 on timeout.
    task automatic run_until(input int kind, input int div, input int max,
                             output int cyc, output int pulses);
        bit seen;
        cyc = -1;
        pulses = 0;
        for (int i = 1; i <= max; i++) begin
            bit pe;
            pe = (gcnt % div) == 0;
            if (pe) pulses++;
            step(1'b0, pe);
            seen = (kind == 0) ? line_start : (kind == 1) ? frame_start : game_tick;
            if (seen) begin
                cyc = i;
                break;
            end
        end
    endtask

    typedef struct {
        bit r;
        bit pe;
        int ex;
        int ey;
        bit ehs;
        bit evo;
        bit els;
    } vec_t;

    vec_t tbl[7];
    int   cyc, pulses, strobes;

    initial begin
        tbl[0] = '{0, 0, 0, 0, 1, 1, 0};
        tbl[1] = '{0, 1, 1, 0, 1, 1, 0};
        tbl[2] = '{0, 1, 2, 0, 1, 1, 0};
        tbl[3] = '{1, 1, 0, 0, 1, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 1, 1, 0, 1, 1, 0};
        tbl[6] = '{0, 0, 1, 0, 1, 1, 0};

        // Reset for 3 cycles, then idle: nothing may move or pulse.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            strobes += int'(line_start) + int'(frame_start) + int'(game_tick);
        end
        check("idle_x", int'(x), 0);
        check("idle_strobes", strobes, 0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].r, tbl[i].pe);
            check($sformatf("tbl%0d_x", i), int'(x), tbl[i].ex);
            check($sformatf("tbl%0d_y", i), int'(y), tbl[i].ey);
            check($sformatf("tbl%0d_hsync", i), int'(hsync), int'(tbl[i].ehs));
            check($sformatf("tbl%0d_video_on", i), int'(video_on), int'(tbl[i].evo));
            check($sformatf("tbl%0d_line_start", i), int'(line_start), int'(tbl[i].els));
        end

        // Stall just before hsync asserts.
        for (int i = 0; i < 200 && x != 10'(HV + HF - 1); i++) step(1'b0, 1'b1);
        check("stall_reach_x", int'(x), HV + HF - 1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        check("stall_hold_x", int'(x), HV + HF - 1);
        check("stall_hold_hsync", int'(hsync), 1);
        step(1'b0, 1'b1);
        check("stall_release_x", int'(x), HV + HF);
        check("stall_release_hsync", int'(hsync), 0);

        // Line period at 1-of-4 pix_en, y steps on each line_start.
        run_until(0, 4, 4 * HT + 8, cyc, pulses);
        check("line_first_seen", int'(cyc > 0), 1);
        check("line_start_x", int'(x), 0);
        begin
            int y0;
            y0 = int'(y);
            run_until(0, 4, 4 * HT + 8, cyc, pulses);
            check("line_period_clk", cyc, 4 * HT);
            check("line_y_incr", int'(y), (y0 + 1) % VT);
        end

        // Mid-frame reset concurrent with pix_en, then a full frame to frame_start.
        for (int i = 0; i < 2 * FT && !(x == 10'd7 && y == 10'd5); i++) step(1'b0, 1'b1);
        check("mid_reach", int'({x, y}), int'({10'd7, 10'd5}));
        step(1'b1, 1'b1);
        check("mid_rst_xy", int'({x, y}), 0);
        check("mid_rst_strobes", int'({line_start, frame_start, game_tick}), 0);
        gcnt = 0;
        run_until(1, 4, 4 * FT + 8, cyc, pulses);
        check("frame_first_clk", cyc, 4 * (FT - 1) + 1);
        check("frame_first_pulses", pulses, FT);
        check("frame_start_xy", int'({x, y}), 0);

        // Game tick with pix_en held high.
`ifdef VGA_GAME_TICK_EN
        run_until(2, 1, FPT * FT + 8, cyc, pulses);
        check("tick_first_seen", int'(cyc > 0), 1);
        check("tick_with_frame", int'(frame_start), 1);
        run_until(2, 1, FPT * FT + 8, cyc, pulses);
        check("tick_period_clk", cyc, FPT * FT);
        check("tick_with_frame2", int'(frame_start), 1);
`else
        run_until(2, 1, 3 * FPT * FT, cyc, pulses);
        check("tick_never", cyc, -1);
`endif

        // Random pix_en duty with occasional resets, all against the model.
        for (int i = 0; i < 6000; i++)
            step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
